mips_wb_trace_buffer: RTL and testbench
=======================================

Name: mips_wb_trace_buffer

Overview:
- Parametrised register-writeback trace buffer for the multicycle MIPS core.
- Captures each retired register write (PC, A3, WD3) into a DEPTH-entry buffer when RegWrite is asserted.
- Drained by the bench or a debug port through a valid/ready interface.
- Sits beside the core on the same writeback signals the testbench interface exposes. Gives the scoreboard an ordered, lossless-or-flagged commit stream instead of sampling waveforms.

Parameters:
- PC_W, 32, width of the PC field
- DATA_W, 32, width of the write-data field
- REG_AW, 5, width of the register index (A3)
- DEPTH, 16, number of entries; power of two, at least 2
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- PC  in  PC_W  PC of the instruction performing the write
- A3  in  REG_AW  destination register index
- WD3  in  DATA_W  write-back data
- RegWrite  in  1  capture strobe, one cycle per retired write
- mode  in  1  0 = FIFO (drop new entries when full), 1 = RING (overwrite oldest)
- clear  in  1  synchronous flush
- rd_ready  in  1  consumer accepts the head entry
- rd_valid  out  1  head entry present
- rd_pc  out  PC_W  head PC
- rd_a3  out  REG_AW  head register index
- rd_wd  out  DATA_W  head data
- count  out  CNT_W  occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- lost  out  1  sticky: at least one entry was dropped or overwritten

Behaviour:
- Reset (async, active-high) forces: pointers = 0, count = 0, empty = 1, full = 0, rd_valid = 0, lost = 0. rd_pc, rd_a3 and rd_wd are 0 while empty.
- Reset asserted mid-operation discards all entries immediately. Storage contents need not be cleared.
- Push condition: RegWrite && A3 != 0. Writes to $zero are never captured.
- Entry is stored at the clk edge. It is visible at the read side the following cycle, so latency is 1 cycle from push to rd_valid.
- Read side is first-word-fall-through:
  - rd_valid = !empty.
  - rd_* show the head entry combinationally from the storage array.
  - Pop on rd_valid && rd_ready.
- Occupancy state (empty / partial / full) derives from count. Pointers wrap modulo DEPTH.
- Push and pop in the same cycle: both happen, count unchanged. This applies at full in both modes; no loss, lost unchanged.
- Push while full without pop, FIFO mode: entry discarded, lost <= 1, buffer unchanged.
- Push while full without pop, RING mode: entry written at the tail, head advances by one, count stays DEPTH, lost <= 1.
- Pop while empty: ignored.
- clear: sync flush, next state equals the reset state. clear has priority over a same-cycle push and pop.
- mode is sampled every cycle. A change takes effect for the next push. Existing contents are untouched.

Optional Feature:
- Macro TRACE_TIMESTAMP_EN.
- When defined:
  - Adds parameter TS_W (default 16) and output rd_ts [TS_W].
  - A free-running cycle counter (0 at reset, cleared by clear, wraps at 2^TS_W) is stored with each entry.
  - rd_ts shows the head timestamp, which equals the counter value at the capture edge.
- When undefined: no counter, no rd_ts port, no timestamp storage.

Test Plan:
- Reset then idle 5 cycles -> empty = 1, count = 0, rd_valid = 0, lost = 0.
- Push (PC=0x0000_0010, A3=8, WD3=0x0000_0005) with rd_ready = 0 -> next cycle rd_valid = 1, rd_pc = 0x10, rd_a3 = 8, rd_wd = 5, count = 1. Then rd_ready = 1 for one cycle -> empty = 1.
- RegWrite = 1 with A3 = 0 -> count stays 0, rd_valid stays 0.
- FIFO mode: 17 pushes with WD3 = 1..17 and no reads -> full = 1, count = 16, lost = 1. Draining returns 1..16 in order; 17 is absent.
- RING mode: same 17 pushes -> count = 16, lost = 1. Draining returns 2..17. Then clear -> empty = 1, lost = 0.
- Full buffer, push and pop in the same cycle (WD3 = 0xAA) -> count stays 16, lost unchanged, 0xAA appears last on drain. Asserting reset mid-drain -> rd_valid = 0 with no clock edge required.

Source files
------------

// File: rtl/mips_wb_trace_buffer.sv
// mips_wb_trace_buffer: writeback trace buffer (FIFO drop / RING overwrite) with FWFT valid/ready drain.
// Define TRACE_TIMESTAMP_EN to store a free-running cycle timestamp with each entry (rd_ts).
module mips_wb_trace_buffer #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
`ifdef TRACE_TIMESTAMP_EN
    ,
    parameter int TS_W   = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   PC,
    input  logic [REG_AW-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              RegWrite,
    input  logic              mode,
    input  logic              clear,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [PC_W-1:0]   rd_pc,
    output logic [REG_AW-1:0] rd_a3,
    output logic [DATA_W-1:0] rd_wd,
`ifdef TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]   rd_ts,
`endif
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              lost
);
    localparam int AW = $clog2(DEPTH);

    logic [PC_W-1:0]   mem_pc [DEPTH];
    logic [REG_AW-1:0] mem_a3 [DEPTH];
    logic [DATA_W-1:0] mem_wd [DEPTH];
    logic [AW-1:0]     head, tail;
    logic              push, pop, wr, adv, inc, dec, drop;

    assign empty    = count == '0;
    assign full     = count == CNT_W'(DEPTH);
    assign rd_valid = !empty;
    assign rd_pc    = empty ? '0 : mem_pc[head];
    assign rd_a3    = empty ? '0 : mem_a3[head];
    assign rd_wd    = empty ? '0 : mem_wd[head];

    assign push = RegWrite && A3 != '0;
    assign pop  = rd_valid && rd_ready;
    // At full without a pop, RING still writes and drags the head along; FIFO drops
    assign wr   = push && (!full || pop || mode);
    assign adv  = pop || (wr && full);
    assign inc  = wr && !pop && !full;
    assign dec  = pop && !wr;
    assign drop = push && full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            lost  <= 1'b0;
        end else begin
            if (wr) tail <= tail + 1'b1;
            if (adv) head <= head + 1'b1;
            if (inc) count <= count + 1'b1;
            else if (dec) count <= count - 1'b1;
            if (drop) lost <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_pc[tail] <= PC;
            mem_a3[tail] <= A3;
            mem_wd[tail] <= WD3;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] mem_ts [DEPTH];

    assign rd_ts = empty ? '0 : mem_ts[head];

    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) ts <= '0;
        else ts <= ts + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr) mem_ts[tail] <= ts;
    end
`endif
endmodule

// File: tb/tb_mips_wb_trace_buffer.sv
// tb_mips_wb_trace_buffer: directed vectors, corner sequences and random traffic against a queue model.
module tb_mips_wb_trace_buffer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0, reset = 1'b1;
    logic [31:0] PC = '0, WD3 = '0;
    logic [4:0]  A3 = '0;
    logic        RegWrite = 1'b0, mode = 1'b0, clear = 1'b0, rd_ready = 1'b0;
    logic        rd_valid, full, empty, lost;
    logic [31:0] rd_pc, rd_wd;
    logic [4:0]  rd_a3;
    logic [4:0]  count;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] rd_ts;
`endif

    mips_wb_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .PC(PC), .A3(A3), .WD3(WD3), .RegWrite(RegWrite),
        .mode(mode), .clear(clear), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_pc(rd_pc), .rd_a3(rd_a3), .rd_wd(rd_wd),
`ifdef TRACE_TIMESTAMP_EN
        .rd_ts(rd_ts),
`endif
        .count(count), .full(full), .empty(empty), .lost(lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [15:0] ts;
    } ent_t;

    ent_t        q[$];
    logic        mlost = 1'b0;
    logic [15:0] mts = '0;
    int          checks = 0, failures = 0;

    typedef struct {
        logic        rw;
        logic [4:0]  a3;
        logic [31:0] pc, wd;
        logic        rr, md, cl;
        int          ecount;
        logic        evalid;
        logic [31:0] epc, ewd;
    } vec_t;
    vec_t vt[6];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mlost = 1'b0;
        mts = '0;
    endtask

    // Buffer rules: pop first, then a push fits unless still full; full RING evicts the oldest
    task automatic model_update();
        ent_t e;
        if (clear) begin
            model_reset();
            return;
        end
        e.pc = PC; e.a3 = A3; e.wd = WD3; e.ts = mts;
        if (q.size() != 0 && rd_ready) void'(q.pop_front());
        if (RegWrite && A3 != 0) begin
            if (q.size() < DEPTH) q.push_back(e);
            else begin
                mlost = 1'b1;
                if (mode) begin
                    void'(q.pop_front());
                    q.push_back(e);
                end
            end
        end
        mts = mts + 16'd1;
    endtask

    task automatic compare_all();
        bit ne = q.size() != 0;
        chk("rd_valid", rd_valid, ne);
        chk("count", count, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, !ne);
        chk("lost", lost, mlost);
        chk("rd_pc", rd_pc, ne ? q[0].pc : 32'h0);
        chk("rd_a3", rd_a3, ne ? q[0].a3 : 5'h0);
        chk("rd_wd", rd_wd, ne ? q[0].wd : 32'h0);
`ifdef TRACE_TIMESTAMP_EN
        chk("rd_ts", rd_ts, ne ? q[0].ts : 16'h0);
`endif
    endtask

    task automatic step(input logic rw, input logic [4:0] a, input logic [31:0] pc, input logic [31:0] wd,
                        input logic rr, input logic md, input logic cl);
        RegWrite = rw; A3 = a; PC = pc; WD3 = wd; rd_ready = rr; mode = md; clear = cl;
        @(posedge clk);
        model_update();
        #1 compare_all();
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, mode, 1'b0);
    endtask

    task automatic fill(input int first, input int last, input logic md);
        for (int i = first; i <= last; i++)
            step(1'b1, 5'(i % 31 + 1), 32'(32'h400 + 4 * i), 32'(i), 1'b0, md, 1'b0);
    endtask

    initial begin
        vt[0] = '{1'b1, 5'd8, 32'h10, 32'h5,  1'b0, 1'b0, 1'b0, 1, 1'b1, 32'h10, 32'h5};
        vt[1] = '{1'b0, 5'd0, 32'h0,  32'h0,  1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h0,  32'h0};
        vt[2] = '{1'b1, 5'd0, 32'h20, 32'h77, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0,  32'h0};
        vt[3] = '{1'b1, 5'd3, 32'h30, 32'h33, 1'b0, 1'b0, 1'b0, 1, 1'b1, 32'h30, 32'h33};
        vt[4] = '{1'b1, 5'd4, 32'h34, 32'h44, 1'b1, 1'b0, 1'b0, 1, 1'b1, 32'h34, 32'h44};
        vt[5] = '{1'b1, 5'd5, 32'h38, 32'h55, 1'b1, 1'b0, 1'b1, 0, 1'b0, 32'h0,  32'h0};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) idle();
        chk("reset_empty", empty, 1'b1);
        chk("reset_count", count, 0);
        chk("reset_valid", rd_valid, 1'b0);
        chk("reset_lost", lost, 1'b0);

        for (int i = 0; i < 6; i++) begin
            step(vt[i].rw, vt[i].a3, vt[i].pc, vt[i].wd, vt[i].rr, vt[i].md, vt[i].cl);
            chk($sformatf("vec%0d_count", i), count, vt[i].ecount);
            chk($sformatf("vec%0d_valid", i), rd_valid, vt[i].evalid);
            chk($sformatf("vec%0d_pc", i), rd_pc, vt[i].epc);
            chk($sformatf("vec%0d_wd", i), rd_wd, vt[i].ewd);
        end

        fill(1, 17, 1'b0);
        chk("fifo_full", full, 1'b1);
        chk("fifo_count", count, 16);
        chk("fifo_lost", lost, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            chk("fifo_drain", rd_wd, i);
            step(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        end
        chk("fifo_drained", empty, 1'b1);
        step(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        fill(1, 17, 1'b1);
        chk("ring_count", count, 16);
        chk("ring_lost", lost, 1'b1);
        for (int i = 2; i <= 17; i++) begin
            chk("ring_drain", rd_wd, i);
            step(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        end
        fill(1, 3, 1'b1);
        step(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("clear_empty", empty, 1'b1);
        chk("clear_lost", lost, 1'b0);

        fill(1, 16, 1'b0);
        step(1'b1, 5'd9, 32'h900, 32'hAA, 1'b1, 1'b0, 1'b0);
        chk("pushpop_count", count, 16);
        chk("pushpop_lost", lost, 1'b0);
        for (int i = 2; i <= 17; i++) begin
            chk("pushpop_drain", rd_wd, i == 17 ? 32'hAA : 32'(i));
            step(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        end

        fill(1, 4, 1'b0);
        step(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1 chk("async_valid", rd_valid, 1'b0);
        chk("async_count", count, 0);
        model_reset();
        #1 reset = 1'b0;
        idle();

        for (int i = 0; i < 3000; i++) begin
            logic [4:0] a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            step($urandom_range(0, 9) < 7, a, $urandom, $urandom, $urandom_range(0, 9) < 4,
                 (i / 200) % 2 == 1, $urandom_range(0, 63) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
